// File: rtl/sumador_pkg.sv
// Shared encodings for the bit-serial add/subtract controller.
package sumador_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_SUMA  = 1'b0;
  localparam logic OP_RESTA = 1'b1;

endpackage

// File: rtl/sumador_serie_ctrl_fa.sv
// 1-bit full-adder cell shared by the serial datapath.
module sumador_serie_ctrl_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/sumador_serie_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell walked LSB first over WIDTH cycles.
// Optional macro SUMADOR_SAT_EN saturates the final result on signed overflow.
module sumador_serie_ctrl
  import sumador_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             fa_s, fa_cout;
  logic             last_bit;

  sumador_serie_ctrl_fa u_fa (
    .a    (sh_a_q[0]),
    .b    (sh_b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH-1));

  always_comb begin
    state_d     = state_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: the +1 rides in on the carry flop.
          sh_a_d  = a;
          sh_b_d  = (op == OP_RESTA) ? ~b : b;
          carry_d = (op == OP_RESTA);
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sh_a_d   = sh_a_q >> 1;
        sh_b_d   = sh_b_q >> 1;
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        result_d = {fa_s, result_q[WIDTH-1:1]};
        if (last_bit) begin
          carry_out_d = fa_cout;
          overflow_d  = carry_q ^ fa_cout;
`ifdef SUMADOR_SAT_EN
          // sh_a_q[0] is operand A's sign bit at this point.
          if (carry_q ^ fa_cout)
            result_d = sh_a_q[0] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sumador_serie_ctrl.sv
// Directed bench for sumador_serie_ctrl at WIDTH = 8.
module tb_sumador_serie_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, carry_out, overflow;
  logic [WIDTH-1:0] result;

  int n_pass = 0;
  int n_tot  = 0;

  sumador_serie_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Start at E0, optionally pulse start again at E0+glitch_edge, check timing and results.
  task automatic run_op(input string tag, input logic o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] exp_r, input logic exp_c, input logic exp_v,
                        input int glitch_edge);
    int early_done;
    early_done = 0;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = ~x; b = ~y; op = ~o;
    chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
    for (int e = 1; e <= WIDTH; e++) begin
      if (e == glitch_edge) begin
        start = 1'b1; a = 8'h01; b = 8'h01;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (e < WIDTH) early_done += int'(done);
      if (e < WIDTH && busy !== 1'b1) early_done += 100;
    end
    chk({tag, "_early_done_or_busy_drop"}, 32'(early_done), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    chk({tag, "_result"}, 32'(result), 32'(exp_r));
    chk({tag, "_carry"}, 32'(carry_out), 32'(exp_c));
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_v));
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
    chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
    chk({tag, "_result_hold"}, 32'(result), 32'(exp_r));
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_idle_quiet"}, 32'({busy, done}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'({carry_out, overflow}), 32'd0);
    // Start held high during reset must not produce a done.
    start = 1'b1;
    @(posedge clk); #1;
    chk("rst_start_ignored", 32'(busy), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_35_4a", 1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0, 0);
    run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0);
    run_op("sub_50_70", 1'b1, 8'h50, 8'h70, 8'hE0, 1'b0, 1'b0, 0);
`ifdef SUMADOR_SAT_EN
    run_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h7F, 1'b0, 1'b1, 0);
    run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h80, 1'b1, 1'b1, 0);
`else
    run_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 0);
    run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 0);
`endif
    run_op("sub_05_05", 1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 0);
    run_op("glitch_10_20", 1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 3);
    run_op("after_glitch", 1'b1, 8'h03, 8'h01, 8'h02, 1'b1, 1'b0, 0);

    // Mid-operation reset at E0+4.
    start = 1'b1; op = 1'b0; a = 8'hAA; b = 8'h11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_busy_before", 32'(busy), 32'd1);
    chk("midrst_partial_nonzero", 32'(result != 8'h00), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_flags", 32'({carry_out, overflow}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'({busy, done}), 32'd0);
    run_op("add_01_02", 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
